// File: rtl/inst_rom_resp_pkg.sv
// Shared widths, defaults and pipeline-stage record for the instruction-memory responder.
package inst_rom_resp_pkg;

    localparam int          INST_W            = 32;
    localparam int          INST_ADDR_W       = 32;
    localparam int          INST_MEM_NUM_LOG2 = 10;
    localparam int          INST_MEM_LATENCY  = 1;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
    localparam logic        CHIP_ENABLE       = 1'b1;

    typedef struct packed {
        logic                   vld;
        logic [INST_W-1:0]      dat;
        logic [INST_ADDR_W-1:0] addr;
        logic                   err;
    } stage_t;

    function automatic logic is_misaligned(input logic [INST_ADDR_W-1:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_rom_array.sv
// Synchronous 1R1W word array; a read and write to the same index on one edge returns the old word.
module inst_rom_array
    import inst_rom_resp_pkg::*;
#(
    parameter int AW = INST_MEM_NUM_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-read cycles load zero so an empty stage never carries stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= ZERO_WORD;
        end else begin
            rdata <= re ? mem[raddr] : ZERO_WORD;
        end
    end

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: returns the word at pc LATENCY-1 cycles after the sampling edge.
// One request per cycle, no backpressure; flush kills older in-flight fetches but keeps the current one.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int MEM_AW  = INST_MEM_NUM_LOG2,
    parameter int LATENCY = INST_MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic [INST_ADDR_W-1:0] pc,
    input  logic                   flush,
    input  logic                   we,
    input  logic [INST_ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0]      wdata,
    output logic [INST_W-1:0]      inst,
    output logic                   inst_valid,
    output logic [INST_ADDR_W-1:0] inst_addr,
    output logic                   inst_err
);

    logic                   req_ok;
    logic                   s1_vld;
    logic [INST_ADDR_W-1:0] s1_addr;
    logic                   s1_err;
    logic [INST_W-1:0]      rd_dat;
    stage_t                 s1;
    stage_t                 last;
    logic                   unused_addr_bits;

    // Upper address bits alias; only the word index reaches the array.
    assign unused_addr_bits = ^{pc[INST_ADDR_W-1:MEM_AW+2], waddr[INST_ADDR_W-1:MEM_AW+2], waddr[1:0]};

    assign req_ok = (ce == CHIP_ENABLE) && !is_misaligned(pc);

    inst_rom_array #(
        .AW (MEM_AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr[MEM_AW+1:2]),
        .wdata (wdata),
        .re    (req_ok),
        .raddr (pc[MEM_AW+1:2]),
        .rdata (rd_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s1_err  <= 1'b0;
        end else begin
            s1_vld  <= (ce == CHIP_ENABLE);
            s1_addr <= (ce == CHIP_ENABLE) ? pc : '0;
            s1_err  <= (ce == CHIP_ENABLE) && is_misaligned(pc);
        end
    end

    assign s1 = '{vld: s1_vld, dat: rd_dat, addr: s1_addr, err: s1_err};

    generate
        if (LATENCY == 1) begin : g_single
            assign last = s1;
        end else begin : g_pipe
            stage_t pipe_q [LATENCY-1];

            // Flush empties every stage behind stage 1; stage 1 itself holds the request sampled this edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY-1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= flush ? '0 : s1;
                    for (int i = 1; i < LATENCY-1; i++) begin
                        pipe_q[i] <= flush ? '0 : pipe_q[i-1];
                    end
                end
            end

            assign last = pipe_q[LATENCY-2];
        end
    endgenerate

    assign inst_valid = last.vld;
    assign inst       = last.dat;
    assign inst_addr  = last.addr;
    assign inst_err   = last.err;

endmodule
